// File: rtl/mouse_tracker.sv
// Purpose : converts per-packet relative mouse deltas into an absolute, screen-clamped
//           cursor position plus a left-click event held until the consumer acks it.
// Latency : cursor/click outputs update on the 3rd clock edge after MouseToggle flips.
// Backpr. : one pending click at a time (ClickValid/ClickAck); further clicks are
//           dropped and counted, and clicks during the post-ack cooldown are ignored.
//
// Ports:
//   Clk, Reset_n             clock, asynchronous active-low reset
//   MouseX, MouseY           signed 8-bit packet deltas (+X right, +Y down)
//   MouseButtons             button bits, [0] = left
//   MouseToggle              flips once per new packet
//   ClickAck                 consumer accepts the pending click
//   CursorX, CursorY         clamped absolute cursor position
//   ClickValid, ClickX/Y     pending click and the position it happened at
//   DropCount                saturating count of clicks lost to a pending event
module mouse_tracker #(
    parameter int X_MAX      = 639,
    parameter int Y_MAX      = 479,
    parameter int X_INIT     = 320,
    parameter int Y_INIT     = 240,
    parameter int SENS_SHIFT = 0,
    parameter int COOLDOWN   = 2500000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] MouseX,
    input  logic [7:0] MouseY,
    input  logic [7:0] MouseButtons,
    input  logic       MouseToggle,
    input  logic       ClickAck,
    output logic [9:0] CursorX,
    output logic [9:0] CursorY,
    output logic       ClickValid,
    output logic [9:0] ClickX,
    output logic [9:0] ClickY,
    output logic [7:0] DropCount
);

    localparam logic [1:0] MV_IDLE   = 2'd0;
    localparam logic [1:0] MV_ADD    = 2'd1;
    localparam logic [1:0] MV_COMMIT = 2'd2;

    localparam logic [1:0] CK_READY   = 2'd0;
    localparam logic [1:0] CK_PENDING = 2'd1;
    localparam logic [1:0] CK_COOL    = 2'd2;

    localparam logic signed [11:0] X_MAX_S = 12'(X_MAX);
    localparam logic signed [11:0] Y_MAX_S = 12'(Y_MAX);

    logic [1:0]        mv_state;
    logic [1:0]        ck_state;
    logic              toggle_prev;
    logic [7:0]        dx;
    logic [7:0]        dy;
    logic              btn_cap;
    logic              btn_prev;
    logic              btn_rise;
    logic signed [11:0] sum_x;
    logic signed [11:0] sum_y;
    logic signed [11:0] delta_x;
    logic signed [11:0] delta_y;
    logic [9:0]        next_x;
    logic [9:0]        next_y;
    logic [31:0]       cooldown;
    logic              commit_click;
    logic              unused_buttons;

    // Only the left button drives click events.
    assign unused_buttons = ^MouseButtons[7:1];

    // 12 bits hold cursor (max 1023) plus a delta of up to +/-128<<3 without overflow.
    assign delta_x = $signed({{4{dx[7]}}, dx}) <<< SENS_SHIFT;
    assign delta_y = $signed({{4{dy[7]}}, dy}) <<< SENS_SHIFT;

    always_comb begin
        next_x = sum_x[9:0];
        if (sum_x < 12'sd0) begin
            next_x = '0;
        end else if (sum_x > X_MAX_S) begin
            next_x = X_MAX_S[9:0];
        end
    end

    always_comb begin
        next_y = sum_y[9:0];
        if (sum_y < 12'sd0) begin
            next_y = '0;
        end else if (sum_y > Y_MAX_S) begin
            next_y = Y_MAX_S[9:0];
        end
    end

    assign commit_click = (mv_state == MV_COMMIT) && btn_rise;

    // Move pipeline: capture packet, add delta, commit clamped position.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mv_state    <= MV_IDLE;
            toggle_prev <= 1'b0;
            dx          <= '0;
            dy          <= '0;
            btn_cap     <= 1'b0;
            btn_prev    <= 1'b0;
            btn_rise    <= 1'b0;
            sum_x       <= '0;
            sum_y       <= '0;
            CursorX     <= 10'(X_INIT);
            CursorY     <= 10'(Y_INIT);
        end else begin
            case (mv_state)
                MV_IDLE: begin
                    // Toggle is only sampled here: a flip during ADD/COMMIT waits,
                    // and a double flip inside that window is invisible.
                    if (MouseToggle != toggle_prev) begin
                        toggle_prev <= MouseToggle;
                        dx          <= MouseX;
                        dy          <= MouseY;
                        btn_cap     <= MouseButtons[0];
                        mv_state    <= MV_ADD;
                    end
                end
                MV_ADD: begin
                    sum_x    <= $signed({2'b00, CursorX}) + delta_x;
                    sum_y    <= $signed({2'b00, CursorY}) + delta_y;
                    btn_rise <= btn_cap & ~btn_prev;
                    btn_prev <= btn_cap;
                    mv_state <= MV_COMMIT;
                end
                MV_COMMIT: begin
                    CursorX  <= next_x;
                    CursorY  <= next_y;
                    mv_state <= MV_IDLE;
                end
                default: mv_state <= MV_IDLE;
            endcase
        end
    end

    // Click event handshake with post-ack cooldown.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ck_state   <= CK_READY;
            ClickValid <= 1'b0;
            ClickX     <= '0;
            ClickY     <= '0;
            DropCount  <= '0;
            cooldown   <= '0;
        end else begin
            case (ck_state)
                CK_READY: begin
                    if (commit_click) begin
                        ClickValid <= 1'b1;
                        ClickX     <= next_x;
                        ClickY     <= next_y;
                        ck_state   <= CK_PENDING;
                    end
                end
                CK_PENDING: begin
                    // A new click is dropped even if it lands on the ack edge.
                    if (commit_click && (DropCount != 8'hFF)) begin
                        DropCount <= DropCount + 8'd1;
                    end
                    if (ClickAck) begin
                        ClickValid <= 1'b0;
                        cooldown   <= 32'(COOLDOWN);
                        ck_state   <= CK_COOL;
                    end
                end
                CK_COOL: begin
                    if (cooldown == 32'd0) begin
                        ck_state <= CK_READY;
                    end else begin
                        cooldown <= cooldown - 32'd1;
                    end
                end
                default: ck_state <= CK_READY;
            endcase
        end
    end

endmodule

// File: tb/tb_mouse_tracker.sv
module tb_mouse_tracker;

    localparam int XM   = 639;
    localparam int YM   = 479;
    localparam int XI   = 320;
    localparam int YI   = 240;
    localparam int COOL = 16;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [7:0] MouseX;
    logic [7:0] MouseY;
    logic [7:0] MouseButtons;
    logic       MouseToggle;
    logic       ClickAck;
    logic [9:0] CursorX, CursorY, ClickX, ClickY;
    logic       ClickValid;
    logic [7:0] DropCount;
    logic [9:0] s_CursorX, s_CursorY, s_ClickX, s_ClickY;
    logic       s_ClickValid;
    logic [7:0] s_DropCount;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state (abstract: position, pending flag, cooldown flag)
    int mx, my, msx, msy;
    bit mbtn_prev, m_pending, m_cool;
    int m_cx, m_cy, m_drop;

    mouse_tracker #(.COOLDOWN(COOL)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .MouseX(MouseX), .MouseY(MouseY),
        .MouseButtons(MouseButtons), .MouseToggle(MouseToggle), .ClickAck(ClickAck),
        .CursorX(CursorX), .CursorY(CursorY), .ClickValid(ClickValid),
        .ClickX(ClickX), .ClickY(ClickY), .DropCount(DropCount)
    );

    mouse_tracker #(.COOLDOWN(COOL), .SENS_SHIFT(2)) dut_s (
        .Clk(Clk), .Reset_n(Reset_n), .MouseX(MouseX), .MouseY(MouseY),
        .MouseButtons(MouseButtons), .MouseToggle(MouseToggle), .ClickAck(1'b0),
        .CursorX(s_CursorX), .CursorY(s_CursorY), .ClickValid(s_ClickValid),
        .ClickX(s_ClickX), .ClickY(s_ClickY), .DropCount(s_DropCount)
    );

    always #5 Clk = ~Clk;

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".cx"}, int'(CursorX), mx);
        chk({tag, ".cy"}, int'(CursorY), my);
        chk({tag, ".scx"}, int'(s_CursorX), msx);
        chk({tag, ".scy"}, int'(s_CursorY), msy);
        chk({tag, ".vld"}, int'(ClickValid), int'(m_pending));
        chk({tag, ".clx"}, int'(ClickX), m_cx);
        chk({tag, ".cly"}, int'(ClickY), m_cy);
        chk({tag, ".drop"}, int'(DropCount), m_drop);
    endtask

    task automatic model_reset();
        mx = XI; my = YI; msx = XI; msy = YI;
        mbtn_prev = 0; m_pending = 0; m_cool = 0;
        m_cx = 0; m_cy = 0; m_drop = 0;
    endtask

    task automatic send(input int dx, input int dy, input bit b, input string tag);
        bit rise;
        @(negedge Clk);
        MouseX       = 8'(dx);
        MouseY       = 8'(dy);
        MouseButtons = {7'($urandom), b};
        MouseToggle  = ~MouseToggle;
        repeat (3) @(posedge Clk);
        #1;
        mx  = clampi(mx + dx, XM);
        my  = clampi(my + dy, YM);
        msx = clampi(msx + dx * 4, XM);
        msy = clampi(msy + dy * 4, YM);
        rise = b & ~mbtn_prev;
        mbtn_prev = b;
        if (rise && !m_cool) begin
            if (m_pending) begin
                if (m_drop < 255) m_drop++;
            end else begin
                m_pending = 1;
                m_cx = mx;
                m_cy = my;
            end
        end
        chk_all(tag);
    endtask

    task automatic ack(input string tag);
        @(negedge Clk);
        ClickAck = 1'b1;
        @(posedge Clk);
        #1;
        ClickAck = 1'b0;
        if (m_pending) begin
            m_pending = 0;
            m_cool = 1;
        end
        chk({tag, ".vld"}, int'(ClickValid), int'(m_pending));
    endtask

    task automatic wait_cool();
        repeat (COOL + 4) @(posedge Clk);
        m_cool = 0;
    endtask

    initial begin
        Reset_n = 1'b0; MouseX = '0; MouseY = '0; MouseButtons = '0;
        MouseToggle = 1'b0; ClickAck = 1'b0;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        chk_all("reset");
        @(negedge Clk);
        Reset_n = 1'b1;

        // Basic move with fixed expected values.
        send(10, -5, 0, "move1");
        chk("move1.const_x", int'(CursorX), 330);
        chk("move1.const_y", int'(CursorY), 235);

        // Lower clamp: walk to (5,5), then -128,-128.
        send(-128, -128, 0, "walk0");
        send(-128, -128, 0, "walk1");
        send(-128, -128, 0, "walk2");
        send(5, 5, 0, "to5");
        send(-128, -128, 0, "clamp_lo");
        chk("clamp_lo.x", int'(CursorX), 0);
        chk("clamp_lo.y", int'(CursorY), 0);

        // Upper clamp: walk to (630,470), then +127,+127.
        send(127, 127, 0, "up0");
        send(127, 127, 0, "up1");
        send(127, 127, 0, "up2");
        send(127, 89, 0, "up3");
        send(122, 0, 0, "up4");
        chk("at630.x", int'(CursorX), 630);
        send(127, 127, 0, "clamp_hi");
        chk("clamp_hi.x", int'(CursorX), 639);
        chk("clamp_hi.y", int'(CursorY), 479);

        // Click path from a fresh reset.
        @(negedge Clk);
        Reset_n = 1'b0; MouseToggle = 1'b0;
        model_reset();
        @(negedge Clk);
        Reset_n = 1'b1;
        ack("ack_idle");
        send(4, 0, 1, "click1");
        chk("click1.clx_const", int'(ClickX), 324);
        send(3, 0, 1, "hold");
        send(0, 0, 0, "rel");
        send(7, 2, 1, "drop1");
        chk("drop1.const", int'(DropCount), 1);
        chk("drop1.clx_kept", int'(ClickX), 324);
        ack("ack1");
        send(1, 1, 0, "cool_rel");
        send(1, 1, 1, "cool_rise");
        chk("cool.vld", int'(ClickValid), 0);
        chk("cool.drop", int'(DropCount), 1);
        wait_cool();
        send(2, 2, 0, "post_rel");
        send(2, 2, 1, "post_click");
        chk("post_click.vld", int'(ClickValid), 1);

        // Randomised packets against the model.
        for (int i = 0; i < 60; i++) begin
            send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                 1'($urandom_range(0, 1)), "rand");
            if (m_pending && $urandom_range(0, 3) == 0) begin
                ack("rand_ack");
                wait_cool();
            end
        end

        // Asynchronous reset during ADD: no partial commit.
        @(negedge Clk);
        MouseX = 8'd50; MouseY = 8'd50; MouseToggle = ~MouseToggle;
        @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        MouseToggle = 1'b0;
        model_reset();
        #1;
        chk("rst_add.async_x", int'(CursorX), XI);
        @(posedge Clk);
        #1;
        chk_all("rst_add");
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        chk_all("rst_add.after");

        // DropCount saturation.
        send(0, 0, 1, "sat_click");
        for (int i = 0; i < 262; i++) begin
            send(0, 0, 0, "sat_rel");
            send(0, 0, 1, "sat_rise");
        end
        chk("sat.const", int'(DropCount), 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
